// File: rtl/box_pkg.sv
// ---------------------------------------------------------------------------
// box_pkg
// Shared definitions for the box drawer: FSM state encoding, box geometry,
// screen height and default colours.
// ---------------------------------------------------------------------------
package box_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ERASE  = 2'd1,
        ST_DRAW   = 2'd2,
        ST_FINISH = 2'd3
    } box_state_e;

    localparam int BOX_SIZE = 4;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] DEF_FALL_COLOUR = 3'b110;
    localparam logic [2:0] DEF_FLY_COLOUR  = 3'b011;
    localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;

    // True when base + dy lands on a visible row. The sum is taken one bit
    // wider than the row port so a wrap past 127 also reads as off-screen.
    function automatic logic row_visible(input logic [6:0] base, input logic [1:0] dy);
        logic [7:0] full_row;
        full_row = {1'b0, base} + {6'b0, dy};
        return full_row < 8'(SCREEN_H);
    endfunction

endpackage

// File: rtl/box_pixel_counter.sv
// ---------------------------------------------------------------------------
// box_pixel_counter
// 4-bit pixel index for one 4x4 box pass. clear has priority over enable.
// Ports:
//   clock, resetn  - clock and async active-low reset
//   clear          - synchronous return to 0
//   enable         - advance by one (wraps 15 -> 0)
//   count          - current pixel index, dx = count[1:0], dy = count[3:2]
//   last           - high while count is 15
// ---------------------------------------------------------------------------
module box_pixel_counter (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'd15);

endmodule

// File: rtl/box_drawer.sv
// ---------------------------------------------------------------------------
// box_drawer
// Redraws a 4x4 box at a fixed column once per frame_tick: erases the box at
// its previous row (background colour), draws it at the newly latched row,
// then pulses done. Ticks arriving while busy are dropped.
//
// Optional build macro BOX_DRAWER_CLIP_EN: pixels whose row lands past the
// bottom of the screen (row > 119, including wraps past 127) are emitted with
// plot = 0; the counter still advances so redraw timing is unchanged.
// Without it every pixel is plotted and rows wrap modulo 128.
//
// Ports:
//   clock, resetn        - clock and async active-low reset
//   frame_tick           - one-cycle redraw request
//   y_coordinate, flying - box row / flying flag, latched on an accepted tick
//   vga_x, vga_y         - pixel position to the VGA adapter
//   vga_colour           - pixel colour to the VGA adapter
//   plot                 - VGA write enable
//   busy                 - high whenever the FSM is not IDLE
//   done                 - one-cycle pulse at the end of a redraw
//
// state  | meaning
// IDLE   | waiting for frame_tick; outputs hold, plot/done low
// ERASE  | 16 cycles painting the old box position in BG_COLOUR
// DRAW   | 16 cycles painting the new box position
// FINISH | one cycle: done high, remember new row as the previous row
// ---------------------------------------------------------------------------
module box_drawer
    import box_pkg::*;
#(
    parameter logic [7:0] BOX_X       = 8'd20,
    parameter logic [2:0] FALL_COLOUR = DEF_FALL_COLOUR,
    parameter logic [2:0] FLY_COLOUR  = DEF_FLY_COLOUR,
    parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [6:0] y_coordinate,
    input  logic       flying,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    box_state_e state;
    logic [6:0] new_y;
    logic       new_fly;
    logic [6:0] prev_y;
    logic       have_prev;

    logic [3:0] cnt;
    logic       cnt_last;
    logic       cnt_clear;
    logic       cnt_en;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [6:0] row_base;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       pix_plot;

    // Counter restarts on an accepted tick and again between erase and draw.
    assign cnt_clear = ((state == ST_IDLE) && frame_tick) ||
                       ((state == ST_ERASE) && cnt_last);
    assign cnt_en    = (state == ST_ERASE) || (state == ST_DRAW);

    box_pixel_counter u_counter (
        .clock  (clock),
        .resetn (resetn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    assign dx       = cnt[1:0];
    assign dy       = cnt[3:2];
    assign row_base = (state == ST_ERASE) ? prev_y : new_y;
    assign pix_x    = BOX_X + {6'b0, dx};
    assign pix_y    = row_base + {5'b0, dy};

`ifdef BOX_DRAWER_CLIP_EN
    assign pix_plot = row_visible(row_base, dy);
`else
    assign pix_plot = 1'b1;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            new_y      <= 7'd0;
            new_fly    <= 1'b0;
            prev_y     <= 7'd0;
            have_prev  <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    if (frame_tick) begin
                        new_y   <= y_coordinate;
                        new_fly <= flying;
                        state   <= have_prev ? ST_ERASE : ST_DRAW;
                    end
                end
                ST_ERASE: begin
                    vga_x      <= pix_x;
                    vga_y      <= pix_y;
                    vga_colour <= BG_COLOUR;
                    plot       <= pix_plot;
                    if (cnt_last) begin
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    vga_x      <= pix_x;
                    vga_y      <= pix_y;
                    vga_colour <= new_fly ? FLY_COLOUR : FALL_COLOUR;
                    plot       <= pix_plot;
                    if (cnt_last) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    plot      <= 1'b0;
                    done      <= 1'b1;
                    prev_y    <= new_y;
                    have_prev <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_box_drawer.sv
module tb_box_drawer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic [6:0] y_coordinate;
    logic       flying;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];

    box_drawer dut (
        .clock        (clock),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .y_coordinate (y_coordinate),
        .flying       (flying),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Queue the expected plotted pixels of one 16-pixel pass, as {x, y, colour}.
    task automatic push_pass(input logic [6:0] row, input logic [2:0] colour);
        logic [7:0] full_row;
        logic [7:0] px;
        logic       vis;
        for (int p = 0; p < 16; p++) begin
            full_row = {1'b0, row} + 8'(p / 4);
            px       = 8'd20 + 8'(p % 4);
`ifdef BOX_DRAWER_CLIP_EN
            vis = (full_row < 8'd120);
`else
            vis = 1'b1;
`endif
            if (vis) exp_q.push_back({px, full_row[6:0], colour});
        end
    endtask

    // One redraw: tick in cycle 0, outputs sampled on each falling edge.
    task automatic run_frame(input string name, input logic [6:0] y, input logic fly,
                             input logic erase, input logic [6:0] prev,
                             input logic [6:0] draw_y, input int tick_a,
                             input int tick_b, input int tick_c, input int chg_cyc);
        int c;
        int done_at;
        int ndone;
        logic [17:0] e;
        logic [6:0] last_row;
        exp_q.delete();
        if (erase) push_pass(prev, 3'b000);
        push_pass(draw_y, fly ? 3'b011 : 3'b110);
        @(negedge clock);
        y_coordinate = y;
        flying       = fly;
        frame_tick   = 1'b1;
        c       = 0;
        done_at = -1;
        ndone   = 0;
        while (c < 90 && (done_at < 0 || c < done_at + 4)) begin
            @(negedge clock);
            c++;
            frame_tick = (c == tick_a) || (c == tick_b) || (c == tick_c);
            if (c == chg_cyc) y_coordinate = 7'd90;
            if (c == 1) begin
                check({name, ".busy_start"}, busy, 1);
                check({name, ".plot_lat"}, plot, 0);
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (plot) begin
                if (exp_q.size() == 0) begin
                    check({name, ".extra_plot"}, {vga_x, vga_y, vga_colour}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({name, ".pixel"}, {vga_x, vga_y, vga_colour}, e);
                end
            end
        end
        frame_tick = 1'b0;
        last_row = draw_y + 7'd3;
        check({name, ".done_cycle"}, done_at, erase ? 34 : 18);
        check({name, ".done_count"}, ndone, 1);
        check({name, ".missing_plots"}, exp_q.size(), 0);
        check({name, ".busy_end"}, busy, 0);
        check({name, ".hold_x"}, vga_x, 23);
        check({name, ".hold_y"}, vga_y, last_row);
        check({name, ".hold_colour"}, vga_colour, fly ? 3'b011 : 3'b110);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        frame_tick   = 1'b0;
        y_coordinate = 7'd0;
        flying       = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.plot", plot, 0);
        check("rst.done", done, 0);
        check("rst.busy", busy, 0);
        check("rst.pixel", {vga_x, vga_y, vga_colour}, 0);
        resetn = 1'b1;
        @(negedge clock);

        run_frame("first", 7'd60, 1'b0, 1'b0, 7'd0, 7'd60, -1, -1, -1, -1);
        run_frame("second", 7'd61, 1'b1, 1'b1, 7'd60, 7'd61, -1, -1, -1, -1);
        run_frame("ign_ticks", 7'd30, 1'b0, 1'b1, 7'd61, 7'd30, 5, 20, 33, -1);
        run_frame("y_change", 7'd40, 1'b0, 1'b1, 7'd30, 7'd40, -1, -1, -1, 3);

        // Reset in the middle of a draw pass.
        @(negedge clock);
        y_coordinate = 7'd50;
        flying       = 1'b1;
        frame_tick   = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        repeat (10) @(negedge clock);
        check("midrst.plot_before", plot, 1);
        resetn = 1'b0;
        #1;
        check("midrst.plot", plot, 0);
        check("midrst.busy", busy, 0);
        check("midrst.pixel", {vga_x, vga_y, vga_colour}, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        run_frame("after_rst", 7'd70, 1'b0, 1'b0, 7'd0, 7'd70, -1, -1, -1, -1);
        run_frame("bottom", 7'd118, 1'b0, 1'b1, 7'd70, 7'd118, -1, -1, -1, -1);
        run_frame("wrap", 7'd126, 1'b1, 1'b1, 7'd118, 7'd126, -1, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
